// File: rtl/sc_lane_scheduler_if.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// sc_lane_scheduler_if
// Bundle between the Frogger lane move scheduler and its neighbours: the game
// state machine (level, pause) and the obstacle lane registers (shift strobes,
// shift directions, overrun status).
//
//   SC_LANESCHED_Level_In     4          level code; 0..3 play, else non-play
//   SC_LANESCHED_Pause_InLow  1          0 = freeze scheduling
//   SC_LANESCHED_Tick_Out     NUM_LANES  one-hot single-cycle shift strobe
//   SC_LANESCHED_Dir_Out      NUM_LANES  per-lane shift direction (1 = left)
//   SC_LANESCHED_Overrun_Out  1          sticky overrun flag
//
// Modports:
//   master - the scheduler (originates the lane strobes)
//   slave  - the environment (drives level/pause, consumes strobes)
// -----------------------------------------------------------------------------
interface sc_lane_scheduler_if #(
  parameter int NUM_LANES = 4
);

  logic [3:0]           SC_LANESCHED_Level_In;
  logic                 SC_LANESCHED_Pause_InLow;
  logic [NUM_LANES-1:0] SC_LANESCHED_Tick_Out;
  logic [NUM_LANES-1:0] SC_LANESCHED_Dir_Out;
  logic                 SC_LANESCHED_Overrun_Out;

  modport master (
    input  SC_LANESCHED_Level_In,
    input  SC_LANESCHED_Pause_InLow,
    output SC_LANESCHED_Tick_Out,
    output SC_LANESCHED_Dir_Out,
    output SC_LANESCHED_Overrun_Out
  );

  modport slave (
    output SC_LANESCHED_Level_In,
    output SC_LANESCHED_Pause_InLow,
    input  SC_LANESCHED_Tick_Out,
    input  SC_LANESCHED_Dir_Out,
    input  SC_LANESCHED_Overrun_Out
  );

endinterface

// File: rtl/sc_lane_scheduler.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// sc_lane_scheduler
// Lane move scheduler for the Frogger obstacle datapath. A prescaler produces
// a base tick; every lane owns a down-counter whose period depends on the lane
// index and the current level. Expired lanes raise a pending flag and a
// round-robin arbiter forwards at most one pending lane per clock to the
// single-shift-per-clock obstacle datapath as a one-hot strobe.
//
// Ports:
//   SC_LANESCHED_CLOCK_50     in   system clock
//   SC_LANESCHED_RESET_InLow  in   asynchronous active-low reset
//   sched                     if   sc_lane_scheduler_if.master (level, pause,
//                                  tick, direction, overrun)
//
// Parameters:
//   NUM_LANES    number of obstacle lanes (2..8)
//   PRESCALE     clocks per base tick (>= 2)
//   BASE_PERIOD  lane-0 period in base ticks at level 0
//   LANE_STEP    extra base ticks per lane index at level 0
//   CNT_W        width of the lane period counters
//
// Build option:
//   LANESCHED_OVERRUN_EN  when defined, an expiry hitting a lane that is still
//                         pending and not granted sets a sticky Overrun_Out
//                         (cleared by reset or a level change). When undefined
//                         Overrun_Out is tied to 0. Tick behaviour is the same
//                         in both builds.
// -----------------------------------------------------------------------------
module sc_lane_scheduler #(
  parameter int NUM_LANES   = 4,
  parameter int PRESCALE    = 50000,
  parameter int BASE_PERIOD = 200,
  parameter int LANE_STEP   = 40,
  parameter int CNT_W       = 10
) (
  input  logic                SC_LANESCHED_CLOCK_50,
  input  logic                SC_LANESCHED_RESET_InLow,
  sc_lane_scheduler_if.master sched
);

  localparam int PS_W  = $clog2(PRESCALE);
  localparam int PTR_W = $clog2(NUM_LANES);

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_LANES - 1);

  // Per-cycle operating mode, decoded in priority order.
  typedef enum logic [1:0] {
    MODE_LEVEL_CHANGE,
    MODE_IDLE,
    MODE_PAUSED,
    MODE_RUN
  } mode_e;

  // Lane period in base ticks: (BASE + lane*STEP) >> level, never below 1.
  function automatic logic [CNT_W-1:0] period_of(input int lane, input logic [1:0] shift);
    logic [CNT_W-1:0] raw;
    logic [CNT_W-1:0] shifted;
    raw     = CNT_W'(BASE_PERIOD + lane * LANE_STEP);
    shifted = raw >> shift;
    return (shifted == '0) ? CNT_W'(1) : shifted;
  endfunction

  // Odd lanes move left at even levels; odd levels mirror every lane.
  function automatic logic [NUM_LANES-1:0] dir_of(input logic lvl_lsb);
    logic [NUM_LANES-1:0] pat;
    for (int i = 0; i < NUM_LANES; i++) begin
      pat[i] = lvl_lsb ^ (i % 2 == 1);
    end
    return pat;
  endfunction

  logic clk;
  logic rst_n;
  logic [3:0] lvl_in;
  logic pause_n;

  assign clk     = SC_LANESCHED_CLOCK_50;
  assign rst_n   = SC_LANESCHED_RESET_InLow;
  assign lvl_in  = sched.SC_LANESCHED_Level_In;
  assign pause_n = sched.SC_LANESCHED_Pause_InLow;

  logic [3:0]           lvl_q;
  logic [PS_W-1:0]      presc_q;
  logic [CNT_W-1:0]     cnt_q [NUM_LANES];
  logic [NUM_LANES-1:0] pending_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [NUM_LANES-1:0] tick_q;
  logic [NUM_LANES-1:0] dir_q;

  mode_e                mode;
  logic                 base_tick;
  logic [NUM_LANES-1:0] expire;
  logic                 grant_vld;
  logic [PTR_W-1:0]     grant_idx;
  logic [NUM_LANES-1:0] grant_oh;

  // ---------------------------------------------------------------------------
  // Mode decode. A level change wins over everything so a new level always
  // starts from a clean schedule, even when it lands on a non-play screen.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (lvl_in != lvl_q) begin
      mode = MODE_LEVEL_CHANGE;
    end else if (lvl_q >= 4'd4) begin
      mode = MODE_IDLE;
    end else if (!pause_n) begin
      mode = MODE_PAUSED;
    end else begin
      mode = MODE_RUN;
    end
  end

  assign base_tick = (mode == MODE_RUN) && (presc_q == PS_LAST);

  // A counter sitting at 1 on a base tick is an expiry. The <= also covers a
  // zero count, so a corrupted counter still reloads instead of wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    expire = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (base_tick && (cnt_q[i] <= CNT_W'(1))) begin
        expire[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first pending lane at or after the pointer, searched
  // cyclically. Only active in RUN so frozen/idle cycles never grant.
  // ---------------------------------------------------------------------------
  always_comb begin : arbiter
    int               scan;
    logic [PTR_W-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    scan      = 0;
    idx       = '0;
    if (mode == MODE_RUN) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        scan = int'(ptr_q) + k;
        if (scan >= NUM_LANES) begin
          scan = scan - NUM_LANES;
        end
        idx = PTR_W'(scan);
        if (!grant_vld && pending_q[idx]) begin
          grant_vld = 1'b1;
          grant_idx = idx;
        end
      end
      if (grant_vld) begin
        grant_oh[grant_idx] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduler state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q   <= '0;
      presc_q <= '0;
      // NOTE: the lane counters are a small register bank, not a RAM, so each
      // entry gets a defined reset value (the level-0 period).
      for (int i = 0; i < NUM_LANES; i++) begin
        cnt_q[i] <= period_of(i, 2'b00);
      end
      pending_q <= '0;
      ptr_q     <= '0;
      tick_q    <= '0;
      dir_q     <= dir_of(1'b0);
    end else begin
      // NOTE: non-blocking assignments throughout, so every register below
      // sees the pre-edge values of the others regardless of statement order.
      lvl_q <= lvl_in;
      // Direction follows lvl_q, so it settles one cycle after lvl_q moves.
      dir_q <= dir_of(lvl_q[0]);

      unique case (mode)
        MODE_LEVEL_CHANGE: begin
          // Reload from the incoming level; lvl_q only catches up at this edge.
          presc_q <= '0;
          for (int i = 0; i < NUM_LANES; i++) begin
            cnt_q[i] <= period_of(i, lvl_in[1:0]);
          end
          pending_q <= '0;
          ptr_q     <= '0;
          tick_q    <= '0;
        end

        MODE_IDLE: begin
          // Prescaler, counters and pointer hold; stale requests are dropped.
          pending_q <= '0;
          tick_q    <= '0;
        end

        MODE_PAUSED: begin
          tick_q <= '0;
        end

        MODE_RUN: begin
          presc_q <= (presc_q == PS_LAST) ? '0 : presc_q + PS_W'(1);
          if (base_tick) begin
            for (int i = 0; i < NUM_LANES; i++) begin
              cnt_q[i] <= expire[i] ? period_of(i, lvl_q[1:0]) : cnt_q[i] - CNT_W'(1);
            end
          end
          // A lane granted and expiring on the same edge stays pending.
          pending_q <= (pending_q & ~grant_oh) | expire;
          tick_q    <= grant_oh;
          if (grant_vld) begin
            ptr_q <= (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
          end
        end

        default: begin
          tick_q <= '0;
        end
      endcase
    end
  end

  assign sched.SC_LANESCHED_Tick_Out = tick_q;
  assign sched.SC_LANESCHED_Dir_Out  = dir_q;

  // ---------------------------------------------------------------------------
  // Overrun: an expiry merging into a request that is still waiting.
  // ---------------------------------------------------------------------------
`ifdef LANESCHED_OVERRUN_EN
  logic overrun_q;
  logic overrun_evt;

  assign overrun_evt = |(expire & pending_q & ~grant_oh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (mode == MODE_LEVEL_CHANGE) begin
      overrun_q <= 1'b0;
    end else if (overrun_evt) begin
      overrun_q <= 1'b1;
    end
  end

  assign sched.SC_LANESCHED_Overrun_Out = overrun_q;
`else
  assign sched.SC_LANESCHED_Overrun_Out = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Structural invariants of the strobe output.
  // ---------------------------------------------------------------------------
  a_tick_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(tick_q));

  a_tick_only_from_run : assert property (@(posedge clk) disable iff (!rst_n)
    (mode != MODE_RUN) |=> (tick_q == '0));

endmodule

// File: tb/tb_sc_lane_scheduler.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_sc_lane_scheduler
// Bench for sc_lane_scheduler with PRESCALE=4, BASE_PERIOD=8, LANE_STEP=4,
// NUM_LANES=4 (lane periods at level 0: 32/48/64/80 clocks). A second instance
// with PRESCALE=2 provides a lane set that cannot be served in time.
// -----------------------------------------------------------------------------
module tb_sc_lane_scheduler;

  localparam int NL      = 4;
  localparam int PS      = 4;
  localparam int PS_FAST = 2;
  localparam int BP      = 8;
  localparam int LS      = 4;

`ifdef LANESCHED_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sc_lane_scheduler_if #(.NUM_LANES(NL)) bus ();
  sc_lane_scheduler_if #(.NUM_LANES(NL)) bus_fast ();

  sc_lane_scheduler #(
    .NUM_LANES(NL), .PRESCALE(PS), .BASE_PERIOD(BP), .LANE_STEP(LS), .CNT_W(10)
  ) dut (
    .SC_LANESCHED_CLOCK_50   (clk),
    .SC_LANESCHED_RESET_InLow(rst_n),
    .sched                   (bus)
  );

  sc_lane_scheduler #(
    .NUM_LANES(NL), .PRESCALE(PS_FAST), .BASE_PERIOD(BP), .LANE_STEP(LS), .CNT_W(10)
  ) dut_fast (
    .SC_LANESCHED_CLOCK_50   (clk),
    .SC_LANESCHED_RESET_InLow(rst_n),
    .sched                   (bus_fast)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic apply_reset(input logic [3:0] lvl);
    rst_n = 1'b0;
    bus.SC_LANESCHED_Level_In         = lvl;
    bus.SC_LANESCHED_Pause_InLow      = 1'b1;
    bus_fast.SC_LANESCHED_Level_In    = 4'd8;
    bus_fast.SC_LANESCHED_Pause_InLow = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  task automatic quiet_until(input int last_edge, input string name);
    while (edge_n < last_edge) begin
      step();
      check(name, 32'(bus.SC_LANESCHED_Tick_Out), 32'd0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: expiries from run-cycle arithmetic, arbitration by a
  // cyclic search over a pending array.
  // ---------------------------------------------------------------------------
  logic [3:0] m_lvl;
  bit         m_pend [NL];
  int         m_ptr;
  int         m_r;
  logic [3:0] m_tick;
  logic [3:0] m_dir;
  bit         m_ovr;

  function automatic int period(input int lvl, input int lane);
    int p;
    p = (BP + lane * LS) >> (lvl % 4);
    return (p < 1) ? 1 : p;
  endfunction

  function automatic logic [3:0] dir_pat(input int lvl);
    logic [3:0] d;
    for (int i = 0; i < NL; i++) d[i] = ((i % 2) ^ (lvl % 2)) != 0;
    return d;
  endfunction

  task automatic model_reset();
    m_lvl = 4'd0; m_ptr = 0; m_r = 0; m_tick = 4'd0; m_dir = dir_pat(0); m_ovr = 1'b0;
    for (int i = 0; i < NL; i++) m_pend[i] = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] lvl_in, input bit pause_n);
    logic [3:0] nxt_dir;
    bit exp_v [NL];
    int g;
    nxt_dir = dir_pat(int'(m_lvl));
    if (lvl_in != m_lvl) begin
      m_r = 0; m_ptr = 0; m_tick = 4'd0; m_ovr = 1'b0;
      for (int i = 0; i < NL; i++) m_pend[i] = 1'b0;
    end else if (m_lvl >= 4'd4) begin
      m_tick = 4'd0;
      for (int i = 0; i < NL; i++) m_pend[i] = 1'b0;
    end else if (!pause_n) begin
      m_tick = 4'd0;
    end else begin
      g = -1;
      for (int k = 0; k < NL; k++)
        if (g < 0 && m_pend[(m_ptr + k) % NL]) g = (m_ptr + k) % NL;
      for (int i = 0; i < NL; i++)
        exp_v[i] = ((m_r + 1) % (PS * period(int'(m_lvl), i))) == 0;
      for (int i = 0; i < NL; i++)
        if (exp_v[i] && m_pend[i] && i != g) m_ovr = 1'b1;
      for (int i = 0; i < NL; i++)
        m_pend[i] = (m_pend[i] && i != g) || exp_v[i];
      m_tick = (g >= 0) ? 4'(1 << g) : 4'd0;
      if (g >= 0) m_ptr = (g + 1) % NL;
      m_r++;
    end
    m_lvl = lvl_in;
    m_dir = nxt_dir;
  endtask

  // ---------------------------------------------------------------------------
  // Table vectors: level held through reset, first strobe edge and direction.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] level;
    logic [3:0] exp_dir;
    int         exp_edge;   // 0 = no strobe within the window
    logic [3:0] exp_tick;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    int         first_edge;
    logic [3:0] first_val;
    bit         found;
    logic [3:0] lvl_choices [8];
    logic [3:0] cur_lvl;
    bit         cur_pause;

    vecs[0] = '{level: 4'd0, exp_dir: 4'b1010, exp_edge: 33, exp_tick: 4'b0001};
    vecs[1] = '{level: 4'd1, exp_dir: 4'b0101, exp_edge: 18, exp_tick: 4'b0001};
    vecs[2] = '{level: 4'd2, exp_dir: 4'b1010, exp_edge: 10, exp_tick: 4'b0001};
    vecs[3] = '{level: 4'd3, exp_dir: 4'b0101, exp_edge: 6,  exp_tick: 4'b0001};
    vecs[4] = '{level: 4'd8, exp_dir: 4'b1010, exp_edge: 0,  exp_tick: 4'b0000};
    vecs[5] = '{level: 4'd5, exp_dir: 4'b0101, exp_edge: 0,  exp_tick: 4'b0000};

    // Reset state, sampled while reset is held.
    apply_reset(4'd0);
    rst_n = 1'b0;
    #3;
    check("rst_tick", 32'(bus.SC_LANESCHED_Tick_Out), 32'd0);
    check("rst_dir", 32'(bus.SC_LANESCHED_Dir_Out), 32'h0000000a);
    check("rst_ovr", 32'(bus.SC_LANESCHED_Overrun_Out), 32'd0);

    // ---- table-driven first-strobe timing per level ----
    for (int v = 0; v < 6; v++) begin
      apply_reset(vecs[v].level);
      first_edge = 0;
      first_val  = 4'd0;
      for (int e = 1; e <= 40; e++) begin
        step();
        if (first_edge == 0 && bus.SC_LANESCHED_Tick_Out != 4'd0) begin
          first_edge = edge_n;
          first_val  = bus.SC_LANESCHED_Tick_Out;
        end
      end
      check("tbl_first_edge", 32'(first_edge), 32'(vecs[v].exp_edge));
      check("tbl_first_tick", 32'(first_val), 32'(vecs[v].exp_tick));
      check("tbl_dir", 32'(bus.SC_LANESCHED_Dir_Out), 32'(vecs[v].exp_dir));
      check("tbl_ovr", 32'(bus.SC_LANESCHED_Overrun_Out), 32'd0);
    end

    // ---- level 0 -> 3: reload to 1,1,2,2 and back-to-back grants ----
    apply_reset(4'd0);
    quiet_until(20, "l03_pre_quiet");
    bus.SC_LANESCHED_Level_In = 4'd3;
    step();
    check("l03_dir_lag", 32'(bus.SC_LANESCHED_Dir_Out), 32'h0000000a);
    check("l03_change_tick", 32'(bus.SC_LANESCHED_Tick_Out), 32'd0);
    step();
    check("l03_dir", 32'(bus.SC_LANESCHED_Dir_Out), 32'h00000005);
    quiet_until(25, "l03_quiet");
    step();
    check("l03_tick_a", 32'(bus.SC_LANESCHED_Tick_Out), 32'h00000001);
    step();
    check("l03_tick_b", 32'(bus.SC_LANESCHED_Tick_Out), 32'h00000002);
    step();
    check("l03_gap", 32'(bus.SC_LANESCHED_Tick_Out), 32'd0);
    step();
    step();
    check("l03_tick_c", 32'(bus.SC_LANESCHED_Tick_Out), 32'h00000004);
    for (int c = 0; c < 30; c++) begin
      step();
      check("l03_onehot", 32'($onehot0(bus.SC_LANESCHED_Tick_Out)), 32'd1);
    end
    check("l03_no_ovr", 32'(bus.SC_LANESCHED_Overrun_Out), 32'd0);

    // ---- overrun on the PRESCALE=2 instance ----
    apply_reset(4'd0);
    step();
    bus_fast.SC_LANESCHED_Level_In = 4'd3;
    for (int c = 0; c < 40; c++) begin
      step();
      check("ovr_onehot", 32'($onehot0(bus_fast.SC_LANESCHED_Tick_Out)), 32'd1);
    end
    check("ovr_set", 32'(bus_fast.SC_LANESCHED_Overrun_Out), 32'(OVR_EN));
    for (int c = 0; c < 10; c++) begin
      step();
      check("ovr_sticky", 32'(bus_fast.SC_LANESCHED_Overrun_Out), 32'(OVR_EN));
    end
    bus_fast.SC_LANESCHED_Level_In = 4'd0;
    step();
    check("ovr_clear", 32'(bus_fast.SC_LANESCHED_Overrun_Out), 32'd0);

    // ---- pause for 50 clocks delays the first strobe by exactly 50 ----
    apply_reset(4'd0);
    quiet_until(10, "pause_pre");
    bus.SC_LANESCHED_Pause_InLow = 1'b0;
    quiet_until(60, "pause_hold");
    bus.SC_LANESCHED_Pause_InLow = 1'b1;
    quiet_until(82, "pause_post");
    step();
    check("pause_tick", 32'(bus.SC_LANESCHED_Tick_Out), 32'h00000001);

    // ---- lose screen drops pending, back to 0 restarts full periods ----
    apply_reset(4'd0);
    quiet_until(32, "idle_pre");
    bus.SC_LANESCHED_Level_In = 4'd8;
    quiet_until(63, "idle_hold");
    bus.SC_LANESCHED_Level_In = 4'd0;
    quiet_until(96, "idle_restart");
    step();
    check("idle_restart_tick", 32'(bus.SC_LANESCHED_Tick_Out), 32'h00000001);

    // ---- reset in the middle of a four-lane burst ----
    apply_reset(4'd3);
    found = 1'b0;
    for (int s = 0; s < 40 && !found; s++) begin
      step();
      if (bus.SC_LANESCHED_Tick_Out == 4'b0100) found = 1'b1;
    end
    check("burst_found", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("burst_rst_tick", 32'(bus.SC_LANESCHED_Tick_Out), 32'd0);
    check("burst_rst_dir", 32'(bus.SC_LANESCHED_Dir_Out), 32'h0000000a);
    bus.SC_LANESCHED_Level_In = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    edge_n = 0;
    quiet_until(32, "burst_no_stale");
    step();
    check("burst_after_tick", 32'(bus.SC_LANESCHED_Tick_Out), 32'h00000001);

    // ---- randomized run against the reference model ----
    lvl_choices = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd0, 4'd8, 4'd15};
    apply_reset(4'd0);
    model_reset();
    cur_lvl   = 4'd0;
    cur_pause = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 79) == 0) cur_lvl = lvl_choices[$urandom_range(0, 7)];
      if ($urandom_range(0, 29) == 0) cur_pause = ~cur_pause;
      bus.SC_LANESCHED_Level_In    = cur_lvl;
      bus.SC_LANESCHED_Pause_InLow = cur_pause;
      model_step(cur_lvl, cur_pause);
      step();
      check("rnd_tick", 32'(bus.SC_LANESCHED_Tick_Out), 32'(m_tick));
      check("rnd_dir", 32'(bus.SC_LANESCHED_Dir_Out), 32'(m_dir));
      check("rnd_ovr", 32'(bus.SC_LANESCHED_Overrun_Out), 32'(OVR_EN ? m_ovr : 1'b0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
